// File: rtl/dlatch_pkg.sv
// dlatch_pkg: shared snapshot FSM state type and default sizing constants for dlatch_bank.
package dlatch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } snap_state_t;

    localparam int DLATCH_WIDTH_DEF = 8;
    localparam int DLATCH_CH_DEF    = 4;
    localparam int DLATCH_HOLD_DEF  = 2;

endpackage

// File: rtl/dlatch_chan.sv
// dlatch_chan: one enable-qualified registered latch channel (qualify counter, Q and Qvalid).
module dlatch_chan
    import dlatch_pkg::*;
#(
    parameter int WIDTH       = DLATCH_WIDTH_DEF,
    parameter int HOLD_CYCLES = DLATCH_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_valid
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_valid;
    logic             w_open;

    // The edge that completes the qualification window already loads.
    assign w_open = i_en && (int'(r_cnt) + 1 >= HOLD_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_cnt <= i_en ? ((r_cnt == HOLD_MAX) ? r_cnt : r_cnt + 1'b1) : '0;
            if (w_open) begin
                r_q     <= i_d;
                r_valid <= 1'b1;
            end
        end
    end

    assign o_q     = r_q;
    assign o_valid = r_valid;

endmodule

// File: rtl/dlatch_bank.sv
// dlatch_bank: CHANNELS glitch-qualified registered latches plus a 4-phase req/ack snapshot of Q.
// Optional DLATCH_QBAR_EN adds the Qbar = ~Q output.
module dlatch_bank
    import dlatch_pkg::*;
#(
    parameter int WIDTH       = DLATCH_WIDTH_DEF,
    parameter int CHANNELS    = DLATCH_CH_DEF,
    parameter int HOLD_CYCLES = DLATCH_HOLD_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [CHANNELS-1:0]       En,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [CHANNELS-1:0]       Qvalid,
    input  logic                      cap_req,
    output logic                      cap_ack,
    output logic [CHANNELS*WIDTH-1:0] snap
`ifdef DLATCH_QBAR_EN
    ,
    output logic [CHANNELS*WIDTH-1:0] Qbar
`endif
);

    snap_state_t               r_state;
    snap_state_t               w_state_next;
    logic                      w_capture;
    logic [CHANNELS*WIDTH-1:0] r_snap;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        dlatch_chan #(
            .WIDTH      (WIDTH),
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (En[i]),
            .i_d    (D[i*WIDTH +: WIDTH]),
            .o_q    (Q[i*WIDTH +: WIDTH]),
            .o_valid(Qvalid[i])
        );
    end

    // Capture only on the IDLE->ACK transition; ACK persists until req drops.
    always_comb begin
        w_state_next = cap_req ? ACK : IDLE;
        w_capture    = (r_state == IDLE) && cap_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_snap  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) r_snap <= Q;
        end
    end

    assign cap_ack = (r_state == ACK);
    assign snap    = r_snap;

`ifdef DLATCH_QBAR_EN
    assign Qbar = ~Q;
`endif

endmodule

// File: tb/tb_dlatch_bank.sv
// tb_dlatch_bank: directed scenario tasks plus randomized run against a run-length reference model.
module tb_dlatch_bank;

    localparam int W = 8;
    localparam int C = 4;
    localparam int H = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [C*W-1:0] D = '0;
    logic [C-1:0]   En = '0;
    logic           cap_req = 1'b0;
    logic [C*W-1:0] Q;
    logic [C-1:0]   Qvalid;
    logic           cap_ack;
    logic [C*W-1:0] snap;
`ifdef DLATCH_QBAR_EN
    logic [C*W-1:0] Qbar;
`endif

    int n_chk = 0;
    int n_pass = 0;

    int             run [C];
    logic [C*W-1:0] mq;
    logic [C-1:0]   mv;
    logic [C*W-1:0] msnap;
    bit             mack;

    always #5 clk = ~clk;

    dlatch_bank #(.WIDTH(W), .CHANNELS(C), .HOLD_CYCLES(H)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .D      (D),
        .En     (En),
        .Q      (Q),
        .Qvalid (Qvalid),
        .cap_req(cap_req),
        .cap_ack(cap_ack),
        .snap   (snap)
`ifdef DLATCH_QBAR_EN
        ,
        .Qbar   (Qbar)
`endif
    );

    task automatic model_reset();
        for (int c = 0; c < C; c++) run[c] = 0;
        mq = '0;
        mv = '0;
        msnap = '0;
        mack = 0;
    endtask

    // One rising edge: the model sees the inputs as they stood before the edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            if (cap_req && !mack) begin
                msnap = mq;
                mack = 1;
            end else if (!cap_req && mack) mack = 0;
            for (int c = 0; c < C; c++) begin
                run[c] = En[c] ? run[c] + 1 : 0;
                if (En[c] && run[c] >= H) begin
                    mq[c*W +: W] = D[c*W +: W];
                    mv[c] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        En = '0;
        cap_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        D = {C{8'hA5}};
        En = '1;
        rst_n = 1'b0;
        step();
        step();
        n_chk++; if (Q !== '0) $display("FAIL reset_q: got %h want 0", Q); else n_pass++;
        n_chk++; if (Qvalid !== '0) $display("FAIL reset_qvalid: got %b want 0", Qvalid); else n_pass++;
        n_chk++; if (cap_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", cap_ack); else n_pass++;
        n_chk++; if (snap !== '0) $display("FAIL reset_snap: got %h want 0", snap); else n_pass++;
        rst_n = 1'b1;
        step();
        n_chk++; if (Q[7:0] !== 8'h00) $display("FAIL reset_edge1_q0: got %h want 00", Q[7:0]); else n_pass++;
        step();
        n_chk++; if (Q[7:0] !== 8'hA5) $display("FAIL reset_edge2_q0: got %h want a5", Q[7:0]); else n_pass++;
        n_chk++; if (Qvalid !== 4'hF) $display("FAIL reset_edge2_valid: got %b want 1111", Qvalid); else n_pass++;
    endtask

    task automatic test_glitch();
        do_reset();
        D[15:8] = 8'h3C;
        En[1] = 1'b1;
        step();
        En[1] = 1'b0;
        step();
        n_chk++; if (Q[15:8] !== 8'h00) $display("FAIL glitch_q1: got %h want 00", Q[15:8]); else n_pass++;
        n_chk++; if (Qvalid[1] !== 1'b0) $display("FAIL glitch_valid1: got %b want 0", Qvalid[1]); else n_pass++;
        En[1] = 1'b1;
        step();
        n_chk++; if (Q[15:8] !== 8'h00) $display("FAIL qual_edge1_q1: got %h want 00", Q[15:8]); else n_pass++;
        step();
        n_chk++; if (Q[15:8] !== 8'h3C) $display("FAIL qual_edge2_q1: got %h want 3c", Q[15:8]); else n_pass++;
        n_chk++; if (Qvalid[1] !== 1'b1) $display("FAIL qual_valid1: got %b want 1", Qvalid[1]); else n_pass++;
        step();
        En[1] = 1'b0;
    endtask

    task automatic test_track();
        En[2] = 1'b1;
        D[23:16] = 8'h00;
        step();
        for (int v = 1; v <= 3; v++) begin
            D[23:16] = 8'(v);
            step();
            n_chk++; if (Q[23:16] !== 8'(v)) $display("FAIL track_q2: got %h want %h", Q[23:16], 8'(v)); else n_pass++;
        end
        D[23:16] = 8'h04;
        En[2] = 1'b0;
        step();
        n_chk++; if (Q[23:16] !== 8'h03) $display("FAIL hold_q2: got %h want 03", Q[23:16]); else n_pass++;
    endtask

    task automatic test_indep();
        D = 32'h44_33_22_11;
        En = 4'b1010;
        step();
        step();
        En = '0;
        n_chk++; if (Q !== 32'h44_03_22_00) $display("FAIL indep_q: got %h want 44032200", Q); else n_pass++;
    endtask

    task automatic test_snapshot();
        D[7:0] = 8'h55;
        En[0] = 1'b1;
        step();
        step();
        n_chk++; if (Q[7:0] !== 8'h55) $display("FAIL snap_pre_q0: got %h want 55", Q[7:0]); else n_pass++;
        D[7:0] = 8'h66;
        cap_req = 1'b1;
        step();
        n_chk++; if (snap !== 32'h44_03_22_55) $display("FAIL snap_capture: got %h want 44032255", snap); else n_pass++;
        n_chk++; if (cap_ack !== 1'b1) $display("FAIL snap_ack: got %b want 1", cap_ack); else n_pass++;
        n_chk++; if (Q[7:0] !== 8'h66) $display("FAIL snap_load_q0: got %h want 66", Q[7:0]); else n_pass++;
        D[7:0] = 8'h77;
        for (int k = 0; k < 5; k++) begin
            step();
            n_chk++; if (snap[7:0] !== 8'h55 || cap_ack !== 1'b1)
                $display("FAIL snap_hold: got snap0=%h ack=%b want 55/1", snap[7:0], cap_ack); else n_pass++;
        end
        n_chk++; if (Q[7:0] !== 8'h77) $display("FAIL snap_ack_load_q0: got %h want 77", Q[7:0]); else n_pass++;
        cap_req = 1'b0;
        En[0] = 1'b0;
        step();
        n_chk++; if (cap_ack !== 1'b0) $display("FAIL snap_release: got %b want 0", cap_ack); else n_pass++;
    endtask

    task automatic test_midreset();
        cap_req = 1'b1;
        step();
        n_chk++; if (cap_ack !== 1'b1) $display("FAIL mid_ack: got %b want 1", cap_ack); else n_pass++;
        rst_n = 1'b0;
        #2;
        n_chk++; if (cap_ack !== 1'b0) $display("FAIL mid_rst_ack: got %b want 0", cap_ack); else n_pass++;
        n_chk++; if (snap !== '0) $display("FAIL mid_rst_snap: got %h want 0", snap); else n_pass++;
        n_chk++; if (Q !== '0) $display("FAIL mid_rst_q: got %h want 0", Q); else n_pass++;
`ifdef DLATCH_QBAR_EN
        n_chk++; if (Qbar !== '1) $display("FAIL mid_rst_qbar: got %h want ffffffff", Qbar); else n_pass++;
`endif
        cap_req = 1'b0;
        rst_n = 1'b1;
        model_reset();
        D[7:0] = 8'hF0;
        En[0] = 1'b1;
        step();
        step();
        En[0] = 1'b0;
        n_chk++; if (Q[7:0] !== 8'hF0) $display("FAIL mid_load_q0: got %h want f0", Q[7:0]); else n_pass++;
`ifdef DLATCH_QBAR_EN
        n_chk++; if (Qbar[7:0] !== 8'h0F) $display("FAIL qbar_q0: got %h want 0f", Qbar[7:0]); else n_pass++;
`endif
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < C; c++) if ($urandom_range(3) == 0) En[c] = ~En[c];
            D = $urandom;
            if ($urandom_range(4) == 0) cap_req = ~cap_req;
            step();
            n_chk++; if (Q !== mq) $display("FAIL rand_q[%0d]: got %h want %h", n, Q, mq); else n_pass++;
            n_chk++; if (Qvalid !== mv) $display("FAIL rand_valid[%0d]: got %b want %b", n, Qvalid, mv); else n_pass++;
            n_chk++; if (cap_ack !== mack) $display("FAIL rand_ack[%0d]: got %b want %b", n, cap_ack, mack); else n_pass++;
            n_chk++; if (snap !== msnap) $display("FAIL rand_snap[%0d]: got %h want %h", n, snap, msnap); else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_glitch();
        test_track();
        test_indep();
        test_snapshot();
        test_midreset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
